// File: rtl/minutes_hours_counter.sv
// Minutes/hours stage of the 24-hour clock: counts accepted minute ticks,
// emits hour/day carry pulses, and lets SET mode step each field directly.
module minutes_hours_counter #(
    parameter int MIN_MAX = 59,
    parameter int HR_MAX  = 23
) (
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       hour_tick,
    output logic       day_tick
);

    localparam logic [5:0] MinLast = MIN_MAX[5:0];
    localparam logic [4:0] HrLast  = HR_MAX[4:0];

    logic [5:0] min_q, min_d;
    logic [4:0] hr_q, hr_d;
    logic       hour_tick_q, hour_tick_d;
    logic       day_tick_q, day_tick_d;

    logic       min_wrap;
    logic       hr_wrap;
    logic [5:0] min_inc;
    logic [4:0] hr_inc;

    // Any value at or above the limit wraps, so stray states self-heal.
    assign min_wrap = (min_q >= MinLast);
    assign hr_wrap  = (hr_q >= HrLast);
    assign min_inc  = min_wrap ? 6'd0 : min_q + 6'd1;
    assign hr_inc   = hr_wrap ? 5'd0 : hr_q + 5'd1;

    always_comb begin
        min_d       = min_q;
        hr_d        = hr_q;
        hour_tick_d = 1'b0;
        day_tick_d  = 1'b0;
        if (set_mode) begin
            // Fields step independently; a tick arriving here is dropped.
            if (inc_min) begin
                min_d = min_inc;
            end
            if (inc_hr) begin
                hr_d = hr_inc;
            end
        end else if (tick) begin
            min_d = min_inc;
            if (min_wrap) begin
                hour_tick_d = 1'b1;
                hr_d        = hr_inc;
                day_tick_d  = hr_wrap;
            end
        end
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            min_q       <= 6'd0;
            hr_q        <= 5'd0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
        end else begin
            min_q       <= min_d;
            hr_q        <= hr_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
        end
    end

    assign minutes   = min_q;
    assign hours     = hr_q;
    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;

endmodule

// File: doc/minutes_hours_counter.md
# minutes_hours_counter

Receiving end of the per-minute `tick` pulse produced by the seconds stage of the 24-hour clock. It counts minutes 0–59 and hours 0–23 on each accepted tick, and emits one-cycle `hour_tick` and `day_tick` carry pulses. A set mode freezes timekeeping and lets the user step minutes and hours from front-panel inputs. It sits between the seconds counter and the display/BCD conversion logic.

## Interface

Parameters:
- `MIN_MAX`, 59: last minute value before wrap to 0.
- `HR_MAX`, 23: last hour value before wrap to 0.

Ports:
- `clk_1Hz`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tick`  input  1  one-cycle minute pulse from the seconds stage, synchronous to `clk_1Hz`.
- `set_mode`  input  1  level; high = SET behaviour, low = RUN behaviour. Synchronous to `clk_1Hz`.
- `inc_min`  input  1  level; in SET, +1 minute per clock edge while high.
- `inc_hr`  input  1  level; in SET, +1 hour per clock edge while high.
- `minutes`  output  6  current minute, binary 0..MIN_MAX.
- `hours`  output  5  current hour, binary 0..HR_MAX.
- `hour_tick`  output  1  registered one-cycle pulse on a minute→hour carry.
- `day_tick`  output  1  registered one-cycle pulse on an hour→day carry.

## Operation

Reset:
- While `rst` is high, asynchronously: `minutes`=0, `hours`=0, `hour_tick`=0, `day_tick`=0.
- Deassertion takes effect at the next `clk_1Hz` edge.

Modes are selected per edge by the sampled `set_mode`; there is no mode register.

RUN (`set_mode`=0):
- `inc_min` and `inc_hr` are ignored.
- `tick`=1 and `minutes`<MIN_MAX: `minutes`+1.
- `tick`=1 and `minutes`≥MIN_MAX: `minutes`→0 and `hour_tick`←1.
  - Same edge, `hours`<HR_MAX: `hours`+1.
  - Same edge, `hours`≥HR_MAX: `hours`→0 and `day_tick`←1.
- `tick`=0: counters hold.

SET (`set_mode`=1):
- `tick` is discarded; the minute is lost and is not queued.
- `inc_min`=1: `minutes` increments and wraps MIN_MAX→0 with no carry into `hours`.
- `inc_hr`=1: `hours` increments and wraps HR_MAX→0.
- Both high on the same edge: both fields step independently.
- `hour_tick` and `day_tick` never assert in SET.

Pulses:
- `hour_tick` and `day_tick` are cleared to 0 on every edge that does not set them, so they are never high for two consecutive cycles.

Arithmetic:
- Out-of-range values are unreachable. Any increment from a value ≥ max wraps to 0.

## Timing

- Latency: `tick` high at edge N gives updated `minutes`/`hours`/pulses visible after edge N. Because the seconds stage registers `tick`, the minute change appears when `seconds` reads 1; the display accepts this 1 s skew.
- `hour_tick` and `day_tick` are high from edge N to edge N+1, aligned with the wrapped count values.
- SET/RUN switching takes effect on the first edge that samples the new `set_mode` value. No settling cycle is required.
- Reset mid-operation: immediate clear regardless of edge, even if a `tick` or carry pulse is in flight; the pulse is dropped.

## Test plan

- Reset: assert `rst` asynchronously with `minutes`=37, `hours`=14, between edges → outputs read 0/0/0/0 before the next edge; they stay 0 on the first edge after release with `tick`=0.
- Minute count: from 0:00, drive 5 `tick` pulses spaced 60 edges apart → `minutes`=5, `hours`=0, no `hour_tick`.
- Hour carry: preload 13:59 via SET, then RUN with one `tick` → 14:00 and `hour_tick`=1 for exactly one cycle; `day_tick`=0.
- Day rollover: preload 23:59, one `tick` → 00:00; `hour_tick`=1 and `day_tick`=1 together for one cycle, both 0 on the following edge.
- Set mode: `set_mode`=1, `inc_min` held 61 edges from 0:58 → `minutes`=59 and `hours`=0 (no carry). `inc_hr` held 25 edges from 0 → `hours`=1. A `tick` injected during SET changes nothing; both inputs high for one edge steps both fields.
- RUN ignores increments: `set_mode`=0, `inc_min`=`inc_hr`=1 for 10 edges with no `tick` → counts unchanged.
